// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide: radix-2 Booth multiply and non-restoring
// magnitude divide, one iteration per clock, WIDTH iterations per operation.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH:0]   acc_q,    acc_d;     // Booth high half / signed partial remainder
    logic [WIDTH-1:0] q_q,      q_d;       // multiplier shift register / quotient bits
    logic             qm1_q,    qm1_d;
    logic [WIDTH:0]   m_q,      m_d;       // sign-extended multiplicand / divisor magnitude
    logic             neg_q,    neg_d;
    logic             dz_q,     dz_d;
    logic             ovf_q,    ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q,    exc_d;

    logic             start;
    logic             last_iter;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   booth_sum, mul_acc_nx;
    logic [WIDTH-1:0] mul_q_nx;
    logic [WIDTH:0]   div_shift, div_sum;
    logic [WIDTH-1:0] div_q_nx;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));
    assign abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Booth step: recode {q[0], q-1}, then arithmetic shift right of {acc, q}.
    assign booth_sum  = ( q_q[0] & ~qm1_q) ? acc_q - m_q :
                        (~q_q[0] &  qm1_q) ? acc_q + m_q : acc_q;
    assign mul_acc_nx = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    assign mul_q_nx   = {booth_sum[0], q_q[WIDTH-1:1]};

    // Non-restoring step: the quotient bit is the complement of the new remainder sign.
    assign div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign div_sum   = acc_q[WIDTH] ? div_shift + m_q : div_shift - m_q;
    assign div_q_nx  = {q_q[WIDTH-2:0], ~div_sum[WIDTH]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        m_d      = m_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;

        if (start) begin
            cnt_d = '0;
            acc_d = '0;
            qm1_d = 1'b0;
            if (ctrl_MULT) begin
                state_d = S_MUL;
                q_d     = data_operandB;
                m_d     = {data_operandA[WIDTH-1], data_operandA};
            end else begin
                state_d = S_DIV;
                q_d     = abs_a;
                m_d     = {1'b0, abs_b};
                neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                dz_d    = (data_operandB == '0);
                ovf_d   = (data_operandA == MIN_VAL) && (&data_operandB);
            end
        end else begin
            case (state_q)
                S_MUL: begin
                    acc_d = mul_acc_nx;
                    q_d   = mul_q_nx;
                    qm1_d = q_q[0];
                    cnt_d = cnt_q + CW'(1);
                    if (last_iter) begin
                        state_d  = S_DONE;
                        result_d = mul_q_nx;
                        exc_d    = (mul_acc_nx[WIDTH-1:0] != {WIDTH{mul_q_nx[WIDTH-1]}});
                    end
                end
                S_DIV: begin
                    acc_d = div_sum;
                    q_d   = div_q_nx;
                    cnt_d = cnt_q + CW'(1);
                    if (last_iter) begin
                        state_d = S_DONE;
                        if (dz_q) begin
                            result_d = '0;
                            exc_d    = 1'b1;
                        end else if (ovf_q) begin
                            result_d = MIN_VAL;
                            exc_d    = 1'b1;
                        end else begin
                            result_d = neg_q ? -div_q_nx : div_q_nx;
                            exc_d    = 1'b0;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            m_q      <= m_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == S_DONE);
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: hand-computed products/quotients, RDY latency,
// restart-while-busy and asynchronous reset behaviour.
module tb_multdiv_unit;
    logic        clk = 1'b0;
    logic        clr_n = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mul = 1'b0;
    logic        div = 1'b0;
    logic [31:0] result;
    logic        exc;
    logic        rdy;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clk            (clk),
        .clr_n          (clr_n),
        .data_operandA  (a),
        .data_operandB  (b),
        .ctrl_MULT      (mul),
        .ctrl_DIV       (div),
        .data_result    (result),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Start at E0, scramble operands afterwards, then watch negedges k=0..34 (after E_k).
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] opa, input logic [31:0] opb,
                          input logic [31:0] exp_res, input logic exp_exc);
        int lat;
        int pulses;
        @(negedge clk);
        a = opa; b = opb; mul = m; div = d;
        @(posedge clk);
        #1;
        mul = 1'b0; div = 1'b0; a = 32'hDEADBEEF; b = 32'h0;
        check_eq({tag, " busy_after_start"}, 32'(busy), 32'd1);
        lat = -1;
        pulses = 0;
        for (int k = 0; k <= 34; k++) begin
            @(negedge clk);
            if (rdy) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (k == 33) check_eq({tag, " busy_after_E33"}, 32'(busy), 32'd0);
        end
        check_eq({tag, " latency"}, 32'(lat), 32'd32);
        check_eq({tag, " rdy_pulses"}, 32'(pulses), 32'd1);
        check_eq({tag, " result"}, result, exp_res);
        check_eq({tag, " exception"}, 32'(exc), 32'(exp_exc));
        $display("[TB] %s: result=0x%08h exc=%0d latency=%0d pulses=%0d", tag, result, exc, lat, pulses);
    endtask

    initial begin
        int pulses;
        int lat;

        #2 clr_n = 1'b0;
        #1;
        check_eq("reset result", result, 32'h0);
        check_eq("reset exception", 32'(exc), 32'd0);
        check_eq("reset rdy", 32'(rdy), 32'd0);
        check_eq("reset busy", 32'(busy), 32'd0);
        $display("[TB] reset: result=0x%08h exc=%0d rdy=%0d busy=%0d", result, exc, rdy, busy);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;

        run_op("mul 7x-3",         1'b1, 1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        run_op("mul 2^16x2^16",    1'b1, 1'b0, 32'h00010000,  32'h00010000, 32'h00000000, 1'b1);
        run_op("mul min x 1",      1'b1, 1'b0, 32'h80000000,  32'd1,        32'h80000000, 1'b0);
        run_op("div -100/7",       1'b0, 1'b1, 32'hFFFFFF9C,  32'd7,        32'hFFFFFFF2, 1'b0);
        run_op("div 3/-5",         1'b0, 1'b1, 32'd3,         32'hFFFFFFFB, 32'h00000000, 1'b0);
        run_op("div 5/0",          1'b0, 1'b1, 32'd5,         32'h0,        32'h00000000, 1'b1);
        run_op("div min/-1",       1'b0, 1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1);

        // Restart: MUL 3x4 at E0, DIV 20/5 at E10; only the divide completes.
        pulses = 0;
        @(negedge clk);
        a = 32'd3; b = 32'd4; mul = 1'b1;
        @(posedge clk);
        #1 mul = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if (rdy) pulses++;
            if (k == 9) begin
                a = 32'd20; b = 32'd5; div = 1'b1;
            end
        end
        @(posedge clk);
        #1 div = 1'b0;
        lat = -1;
        for (int k = 0; k <= 34; k++) begin
            @(negedge clk);
            if (rdy) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
        check_eq("restart latency", 32'(lat), 32'd32);
        check_eq("restart rdy_pulses", 32'(pulses), 32'd1);
        check_eq("restart result", result, 32'd4);
        check_eq("restart exception", 32'(exc), 32'd0);
        $display("[TB] restart mul3x4->div20/5: result=0x%08h exc=%0d latency=%0d pulses=%0d", result, exc, lat, pulses);

        run_op("mul+div 6,3",      1'b1, 1'b1, 32'd6,         32'd3,        32'd18,       1'b0);

        // Asynchronous reset mid-multiply clears outputs and abandons the operation.
        @(negedge clk);
        a = 32'd9; b = 32'd9; mul = 1'b1;
        @(posedge clk);
        #1 mul = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("hold result before reset", result, 32'd18);
        clr_n = 1'b0;
        #1;
        check_eq("midop reset result", result, 32'h0);
        check_eq("midop reset exception", 32'(exc), 32'd0);
        check_eq("midop reset rdy", 32'(rdy), 32'd0);
        check_eq("midop reset busy", 32'(busy), 32'd0);
        $display("[TB] mid-op reset: result=0x%08h exc=%0d rdy=%0d busy=%0d", result, exc, rdy, busy);
        @(negedge clk);
        clr_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rdy) pulses++;
        end
        check_eq("post-reset rdy_pulses", 32'(pulses), 32'd0);
        check_eq("post-reset busy", 32'(busy), 32'd0);
        $display("[TB] post-reset idle 40 cycles: pulses=%0d busy=%0d", pulses, busy);

        run_op("mul 9x9",          1'b1, 1'b0, 32'd9,         32'd9,        32'd81,       1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed multiply/divide unit in the execute stage.
- Its result and exception flag drive the X/M pipeline register's ALU-result and overflow inputs for MUL/DIV instructions.
- Runs a fixed-length multi-cycle operation and holds `busy` high so hazard logic stalls F/D/X until `data_resultRDY` pulses.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  pipeline clock, rising edge
- clr_n  input  1  asynchronous active-low reset
- data_operandA  input  WIDTH  multiplicand / dividend (signed two's complement)
- data_operandB  input  WIDTH  multiplier / divisor (signed)
- ctrl_MULT  input  1  start multiply; sampled on rising edge
- ctrl_DIV  input  1  start divide; sampled on rising edge
- data_result  output  WIDTH  product low word / quotient
- data_exception  output  1  overflow or divide-by-zero; feeds X/M ovf input
- data_resultRDY  output  1  one-cycle pulse; result and exception valid
- busy  output  1  operation in progress; stall request

Behaviour:
- Reset, asynchronous on clr_n low, every output is 0:
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - State=IDLE, counter=0, internal registers cleared.
  - Reset mid-operation abandons the operation; no RDY pulse follows.
- States:
  - IDLE: wait for a start.
  - MUL: radix-2 Booth, one iteration per cycle.
  - DIV: non-restoring on magnitudes, one iteration per cycle.
  - DONE: one cycle, RDY high, then IDLE.
- Start: at edge E0, ctrl_MULT or ctrl_DIV is high.
  - The operation and both operands are latched at E0; later operand changes are ignored.
  - Counter clears to 0; busy=1 from E0.
- Both ctrl_MULT and ctrl_DIV high at the same edge: MULT wins.
- Start while busy (any state, including DONE): the current operation is aborted and restarted with new operands/op. The aborted operation produces no RDY.
- Iterations run on edges E1..E32, with the counter 0..WIDTH-1. At E32 the state goes to DONE.
  - E33 goes to IDLE, unless a new start is sampled at E33; that start is then taken.
- Output timing:
  - data_resultRDY=1 exactly during the cycle between E32 and E33.
  - busy=1 from E0 through E33; busy=0 after E33 when no restart.
  - Latency: RDY visible 32 cycles after the start edge.
- data_result and data_exception are registered and update at E32.
  - They hold their value until the next completion or reset.
  - They are not cleared at the start of a new operation.
- Multiply:
  - Full 2*WIDTH signed product computed; result = low WIDTH bits.
  - Exception=1 iff the high WIDTH bits are not the sign-extension of result bit WIDTH-1.
- Divide:
  - Signed; quotient truncates toward zero; remainder discarded.
  - Divisor 0: result=0, exception=1, same latency (no early exit).
  - Dividend 0x80000000 with divisor -1: result=0x80000000, exception=1.
  - Quotient sign = signA XOR signB, except a zero quotient is always 0 (never -0 artefact).
- ctrl pulses while in IDLE with clr_n low are ignored.

Test Plan:
- MULT 7 × -3 (0xFFFFFFFD) -> busy 1 from E0; RDY single pulse between E32 and E33; result 0xFFFFFFEB; exception 0; busy 0 after E33.
- MULT 0x00010000 × 0x00010000 -> result 0x00000000, exception 1. Then MULT 0x80000000 × 1 -> result 0x80000000, exception 0.
- DIV -100 / 7 -> result 0xFFFFFFF2 (-14), exception 0. Then DIV 3 / -5 -> result 0, exception 0.
- DIV 5 / 0 -> result 0, exception 1, RDY 32 cycles after start. Then DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000, exception 1.
- Restart: MULT 3×4 at E0, DIV 20/5 at E10 -> no RDY at E0+32; single RDY 32 cycles after E10; result 4. Simultaneous MULT+DIV on 6,3 -> result 18.
- Reset: start MULT 9×9, drive clr_n low at cycle 5 -> all outputs 0 immediately. Release clr_n -> no RDY for 40 cycles; next MULT 9×9 -> 81.
